// File: rtl/rv32_alu_pkg.sv
// Shared RV32 ALU definitions.
// Widths, divider FSM states and constants.
package rv32_alu_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(XLEN - 1);

  localparam logic [XLEN-1:0] DIV_ZERO_QUOT =
    '1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  // Magnitude of v when en and v negative.
  function automatic logic [XLEN-1:0] abs_if(
    input logic [XLEN-1:0] v,
    input logic            en
  );
    if (en && v[XLEN-1])
      return -v;
    return v;
  endfunction

  // Two's-complement negate when en.
  function automatic logic [XLEN-1:0] neg_if(
    input logic [XLEN-1:0] v,
    input logic            en
  );
    if (en)
      return -v;
    return v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step.
// Shifts {rem,quo} left and tries a subtract.
module div_step
  import rv32_alu_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            fits;

  // Trial subtract on the XLEN+1 bit shifted
  // remainder; the kept result is always
  // below the divisor, so XLEN bits suffice.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    fits    = shifted >= {1'b0, divisor};
    diff    = shifted[XLEN-1:0] - divisor;
    if (fits) begin
      rem_nxt = diff;
      quo_nxt = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq_32.sv
// Iterative restoring divider, one bit/cycle.
// DIV/DIVU/REM/REMU with fixed latency.
module div_seq_32
  import rv32_alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] a_net,
  input  logic [XLEN-1:0] b_net,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] o_quot_net,
  output logic [XLEN-1:0] o_rem_net,
  output logic            div_zero
);

  div_state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  rem, quo, divisor;
  logic [XLEN-1:0]  rem_nxt, quo_nxt;
  logic [XLEN-1:0]  a_raw;
  logic             sign_q, sign_r, dz;

  div_step u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (divisor),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == CNT_LAST)
          state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration and sign fix.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      rem        <= '0;
      quo        <= '0;
      divisor    <= '0;
      a_raw      <= '0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
      dz         <= 1'b0;
      o_quot_net <= '0;
      o_rem_net  <= '0;
      div_zero   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= abs_if(a_net, is_signed);
            divisor <= abs_if(b_net, is_signed);
            a_raw   <= a_net;
            sign_q  <= is_signed &
                       (a_net[XLEN-1] ^
                        b_net[XLEN-1]);
            sign_r  <= is_signed &
                       a_net[XLEN-1];
            dz      <= (b_net == '0);
          end
        end
        CALC: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          div_zero <= dz;
          if (dz) begin
            o_quot_net <= DIV_ZERO_QUOT;
            o_rem_net  <= a_raw;
          end else begin
            o_quot_net <= neg_if(quo, sign_q);
            o_rem_net  <= neg_if(rem, sign_r);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_32.sv
// Scoreboard bench for div_seq_32.
// Directed vectors, decoupled monitor.
module tb_div_seq_32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] a_net, b_net;
  logic        busy, done, div_zero;
  logic [31:0] o_quot_net, o_rem_net;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  div_seq_32 dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_signed  (is_signed),
    .a_net      (a_net),
    .b_net      (b_net),
    .busy       (busy),
    .done       (done),
    .o_quot_net (o_quot_net),
    .o_rem_net  (o_rem_net),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Monitor: each done pulse pops one entry.
  // Latency 34 cycles counting the start
  // cycle, i.e. 33 edges after acceptance.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done at %0d",
                 cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quot", o_quot_net, e.q);
        chk("rem", o_rem_net, e.r);
        chk("div_zero", 32'(div_zero),
            32'(e.dz));
        chk("latency", 32'(cyc - e.acc), 32'd33);
      end
    end
  end

  task automatic issue(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s,
    input logic [31:0] eq,
    input logic [31:0] er,
    input logic        edz
  );
    exp_t e;
    @(negedge clk);
    a_net     = a;
    b_net     = b;
    is_signed = s;
    start     = 1'b1;
    e.q   = eq;
    e.r   = er;
    e.dz  = edz;
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for done, then step into the IDLE
  // cycle so the next issue is back-to-back.
  task automatic wait_done;
    bit seen;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL timeout: done %b want 1",
               done);
      sb.delete();
    end
    @(posedge clk);
  endtask

  task automatic op(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s,
    input logic [31:0] eq,
    input logic [31:0] er,
    input logic        edz
  );
    issue(a, b, s, eq, er, edz);
    wait_done();
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    a_net     = '0;
    b_net     = '0;
    repeat (3) @(negedge clk);
    chk("rst_quot", o_quot_net, 32'h0);
    chk("rst_rem", o_rem_net, 32'h0);
    chk("rst_dz", 32'(div_zero), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    reset = 1'b0;

    op(32'd100, 32'd7, 1'b0,
       32'd14, 32'd2, 1'b0);
    op(32'hFFFFFFF9, 32'd2, 1'b1,
       32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    op(32'd7, 32'hFFFFFFFE, 1'b1,
       32'hFFFFFFFD, 32'd1, 1'b0);
    op(32'hFFFFFFFF, 32'd1, 1'b0,
       32'hFFFFFFFF, 32'd0, 1'b0);
    op(32'h1234, 32'd0, 1'b1,
       32'hFFFFFFFF, 32'h1234, 1'b1);
    op(32'h1234, 32'd0, 1'b0,
       32'hFFFFFFFF, 32'h1234, 1'b1);
    op(32'hFFFFFFF9, 32'd0, 1'b1,
       32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1);
    op(32'h80000000, 32'hFFFFFFFF, 1'b1,
       32'h80000000, 32'd0, 1'b0);
    op(32'h80000000, 32'hFFFFFFFF, 1'b0,
       32'd0, 32'h80000000, 1'b0);
    op(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1,
       32'd14, 32'hFFFFFFFE, 1'b0);

    // Start during an op must be ignored.
    issue(32'd1000, 32'd10, 1'b0,
          32'd100, 32'd0, 1'b0);
    repeat (8) @(negedge clk);
    a_net     = 32'd55;
    b_net     = 32'd5;
    is_signed = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Reset mid-operation aborts it.
    issue(32'd77, 32'd3, 1'b0,
          32'd25, 32'd2, 1'b0);
    repeat (18) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    chk("abort_quot", o_quot_net, 32'h0);
    chk("abort_rem", o_rem_net, 32'h0);
    chk("abort_dz", 32'(div_zero), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    repeat (40) @(negedge clk);

    op(32'd77, 32'd3, 1'b0,
       32'd25, 32'd2, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
